// File: rtl/mips_mem_arbiter_if.sv
// mips_mem_arbiter_if: core-side and memory-side bus of the unified memory arbiter
// Ports (as signals):
//   if_req/if_addr -> if_rdata/if_ack                 instruction fetch channel
//   d_req/d_we/d_addr/d_wdata -> d_rdata/d_ack        load/store channel
//   stall                                             core stall
//   mem_en/mem_we/mem_addr/mem_wdata <- mem_rdata     single-port memory macro
// Modports: slave = arbiter view, master = core + memory view.
interface mips_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ack;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ack;
  logic          stall;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack, stall, mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack, stall, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares one single-port memory between MIPS fetch and load/store units
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, released synchronously
//   bus    mips_mem_arbiter_if.slave (fetch channel, data channel, stall, memory macro)
//   perf_conflicts  [15:0] saturating count of IDLE cycles with both requesters eligible
//                   (only when MEM_ARB_PERF_EN is defined)
// Each access occupies the memory for WAIT_CYCLES cycles (1..15); the ack pulse follows
// one cycle later, and that ack cycle may already grant the other requester.
module mips_mem_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int WAIT_CYCLES = 2
) (
  input logic                clk,
  input logic                rst_n,
  mips_mem_arbiter_if.slave  bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [15:0]        perf_conflicts
`endif
);
  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;
  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);
  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          last_grant_q, last_grant_d;
  logic          if_ack_q, if_ack_d;
  logic          d_ack_q, d_ack_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_elig, d_elig, pick_d;
  logic          unused_addr_lsbs;
`ifdef MEM_ARB_PERF_EN
  logic [15:0]   perf_q, perf_d;
`endif
  // A requester whose ack is high this cycle is still dropping its request.
  assign if_elig = bus.if_req & ~if_ack_q;
  assign d_elig  = bus.d_req & ~d_ack_q;
  // last_grant_q = 1 means data was granted last; ties go to the other side.
  assign pick_d  = d_elig & (~if_elig | ~last_grant_q);
  assign unused_addr_lsbs = ^{bus.if_addr[1:0], bus.d_addr[1:0]};
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    if_ack_d     = 1'b0;
    d_ack_d      = 1'b0;
    if_rdata_d   = if_rdata_q;
    d_rdata_d    = d_rdata_q;
    mem_en_d     = mem_en_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    if (state_q == IDLE) begin
      if (if_elig | d_elig) begin
        state_d      = pick_d ? BUSY_D : BUSY_I;
        cnt_d        = CNT_INIT;
        last_grant_d = pick_d;
        mem_en_d     = 1'b1;
        mem_we_d     = pick_d & bus.d_we;
        mem_addr_d   = {(pick_d ? bus.d_addr[AW-1:2] : bus.if_addr[AW-1:2]), 2'b00};
        mem_wdata_d  = pick_d ? bus.d_wdata : mem_wdata_q;
      end
    end else if (cnt_q == 4'd0) begin
      // Last busy cycle: mem_rdata is valid now.
      state_d    = IDLE;
      mem_en_d   = 1'b0;
      mem_we_d   = 1'b0;
      if_ack_d   = state_q == BUSY_I;
      d_ack_d    = state_q == BUSY_D;
      if_rdata_d = (state_q == BUSY_I) ? bus.mem_rdata : if_rdata_q;
      d_rdata_d  = (state_q == BUSY_D && !mem_we_q) ? bus.mem_rdata : d_rdata_q;
    end else begin
      cnt_d = cnt_q - 4'd1;
    end
`ifdef MEM_ARB_PERF_EN
    perf_d = (state_q == IDLE && if_elig && d_elig && perf_q != 16'hFFFF) ? perf_q + 16'd1 : perf_q;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      last_grant_q <= 1'b1;
      if_ack_q     <= 1'b0;
      d_ack_q      <= 1'b0;
      if_rdata_q   <= '0;
      d_rdata_q    <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      if_ack_q     <= if_ack_d;
      d_ack_q      <= d_ack_d;
      if_rdata_q   <= if_rdata_d;
      d_rdata_q    <= d_rdata_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end
`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= 16'd0;
    else perf_q <= perf_d;
  end
  assign perf_conflicts = perf_q;
`endif
  assign bus.if_rdata  = if_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.stall     = (bus.if_req & ~if_ack_q) | (bus.d_req & ~d_ack_q);
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter: cycle table, hand-written held-address sequence and randomized traffic against a memory reference
module tb_mips_mem_arbiter;
  localparam int W = 2;
  localparam logic [31:0] A = 32'h0000_0046;
  localparam logic [31:0] D = 32'h0000_0010;
  localparam logic [31:0] I = 32'h2008_0005;
  localparam logic [31:0] B = 32'hDEAD_BEEF;
  logic clk = 1'b0;
  logic rst_n;
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  mips_mem_arbiter_if #(.AW(32), .DW(32)) bus();
`ifdef MEM_ARB_PERF_EN
  logic [15:0] perf_conflicts;
`endif
  mips_mem_arbiter #(.AW(32), .DW(32), .WAIT_CYCLES(W)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_conflicts(perf_conflicts)
`endif
  );
  logic [31:0] mem_arr [64];
  logic [31:0] ref_mem [64];
  function automatic logic [31:0] init_word(input int i);
    return (i == 17) ? I : 32'h1000_0000 + 32'(i) * 32'h0001_0101;
  endfunction
  initial for (int i = 0; i < 64; i++) mem_arr[i] <= init_word(i);
  always @(posedge clk) if (bus.mem_en && bus.mem_we) mem_arr[bus.mem_addr[7:2]] <= bus.mem_wdata;
  assign bus.mem_rdata = mem_arr[bus.mem_addr[7:2]];
  typedef struct {
    logic rst, ir; logic [31:0] ia; logic dr, dw; logic [31:0] da;
    logic iack, dack, stall, en, we; logic [31:0] maddr, ird, drd; logic [15:0] perf;
  } vec_t;
  vec_t tbl[$];
  task automatic add(input logic rst, ir, input logic [31:0] ia, input logic dr, dw, input logic [31:0] da,
                     input logic iack, dack, stall, en, we, input logic [31:0] maddr, ird, drd, input logic [15:0] perf);
    tbl.push_back('{rst, ir, ia, dr, dw, da, iack, dack, stall, en, we, maddr, ird, drd, perf});
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  int cyc, istart, dstart, lat;
  logic ipend, dpend, dwe_r;
  logic [31:0] ia_r, da_r, dwd_r, exp_drd;
  initial begin
    rst_n = 1'b0;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = B;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    //  rst ir ia  dr dw da | iack dack stall en we maddr ird drd perf
    add(0, 1, A, 0, 0, 0,   0, 0, 1, 0, 0, 32'h00, 0, 0, 0);
    add(1, 1, A, 0, 0, 0,   0, 0, 1, 0, 0, 32'h00, 0, 0, 0);
    add(1, 1, A, 0, 0, 0,   0, 0, 1, 1, 0, 32'h44, 0, 0, 0);
    add(1, 1, A, 0, 0, 0,   0, 0, 1, 1, 0, 32'h44, 0, 0, 0);
    add(1, 1, A, 0, 0, 0,   1, 0, 0, 0, 0, 32'h44, I, 0, 0);
    add(1, 0, A, 0, 0, 0,   0, 0, 0, 0, 0, 32'h44, I, 0, 0);
    add(1, 0, A, 1, 1, D,   0, 0, 1, 0, 0, 32'h44, I, 0, 0);
    add(1, 0, A, 1, 1, D,   0, 0, 1, 1, 1, 32'h10, I, 0, 0);
    add(1, 0, A, 1, 1, D,   0, 0, 1, 1, 1, 32'h10, I, 0, 0);
    add(1, 0, A, 1, 1, D,   0, 1, 0, 0, 0, 32'h10, I, 0, 0);
    add(1, 0, A, 1, 0, D,   0, 0, 1, 0, 0, 32'h10, I, 0, 0);
    add(1, 0, A, 1, 0, D,   0, 0, 1, 1, 0, 32'h10, I, 0, 0);
    add(1, 0, A, 1, 0, D,   0, 0, 1, 1, 0, 32'h10, I, 0, 0);
    add(1, 0, A, 1, 0, D,   0, 1, 0, 0, 0, 32'h10, I, B, 0);
    add(1, 0, A, 0, 0, D,   0, 0, 0, 0, 0, 32'h10, I, B, 0);
    add(0, 0, A, 0, 0, D,   0, 0, 0, 0, 0, 32'h00, 0, 0, 0);
    add(1, 1, A, 1, 0, D,   0, 0, 1, 0, 0, 32'h00, 0, 0, 0);
    add(1, 1, A, 1, 0, D,   0, 0, 1, 1, 0, 32'h44, 0, 0, 1);
    add(1, 1, A, 1, 0, D,   0, 0, 1, 1, 0, 32'h44, 0, 0, 1);
    add(1, 1, A, 1, 0, D,   1, 0, 1, 0, 0, 32'h44, I, 0, 1);
    add(1, 0, A, 1, 0, D,   0, 0, 1, 1, 0, 32'h10, I, 0, 1);
    add(1, 0, A, 1, 0, D,   0, 0, 1, 1, 0, 32'h10, I, 0, 1);
    add(1, 0, A, 1, 0, D,   0, 1, 0, 0, 0, 32'h10, I, B, 1);
    add(1, 0, A, 0, 0, D,   0, 0, 0, 0, 0, 32'h10, I, B, 1);
    add(1, 1, A, 0, 0, D,   0, 0, 1, 0, 0, 32'h10, I, B, 1);
    add(1, 1, A, 0, 0, D,   0, 0, 1, 1, 0, 32'h44, I, B, 1);
    add(1, 1, A, 0, 0, D,   0, 0, 1, 1, 0, 32'h44, I, B, 1);
    add(1, 1, A, 0, 0, D,   1, 0, 0, 0, 0, 32'h44, I, B, 1);
    add(1, 1, A, 0, 0, D,   0, 0, 1, 0, 0, 32'h44, I, B, 1);
    add(1, 1, A, 0, 0, D,   0, 0, 1, 1, 0, 32'h44, I, B, 1);
    add(1, 1, A, 0, 0, D,   0, 0, 1, 1, 0, 32'h44, I, B, 1);
    add(1, 1, A, 0, 0, D,   1, 0, 0, 0, 0, 32'h44, I, B, 1);
    add(1, 0, A, 0, 0, D,   0, 0, 0, 0, 0, 32'h44, I, B, 1);
    add(1, 0, A, 1, 0, D,   0, 0, 1, 0, 0, 32'h44, I, B, 1);
    add(1, 0, A, 1, 0, D,   0, 0, 1, 1, 0, 32'h10, I, B, 1);
    add(0, 0, A, 1, 0, D,   0, 0, 1, 0, 0, 32'h00, 0, 0, 0);
    add(1, 0, A, 1, 0, D,   0, 0, 1, 0, 0, 32'h00, 0, 0, 0);
    add(1, 0, A, 1, 0, D,   0, 0, 1, 1, 0, 32'h10, 0, 0, 0);
    add(1, 0, A, 1, 0, D,   0, 0, 1, 1, 0, 32'h10, 0, 0, 0);
    add(1, 0, A, 1, 0, D,   0, 1, 0, 0, 0, 32'h10, 0, B, 0);
    add(1, 0, A, 0, 0, D,   0, 0, 0, 0, 0, 32'h10, 0, B, 0);
    foreach (tbl[k]) begin
      @(negedge clk);
      rst_n = tbl[k].rst; bus.if_req = tbl[k].ir; bus.if_addr = tbl[k].ia;
      bus.d_req = tbl[k].dr; bus.d_we = tbl[k].dw; bus.d_addr = tbl[k].da;
      #1;
      chk($sformatf("row%0d if_ack", k), 32'(bus.if_ack), 32'(tbl[k].iack));
      chk($sformatf("row%0d d_ack", k), 32'(bus.d_ack), 32'(tbl[k].dack));
      chk($sformatf("row%0d stall", k), 32'(bus.stall), 32'(tbl[k].stall));
      chk($sformatf("row%0d mem_en", k), 32'(bus.mem_en), 32'(tbl[k].en));
      chk($sformatf("row%0d mem_we", k), 32'(bus.mem_we), 32'(tbl[k].we));
      chk($sformatf("row%0d mem_addr", k), bus.mem_addr, tbl[k].maddr);
      chk($sformatf("row%0d if_rdata", k), bus.if_rdata, tbl[k].ird);
      chk($sformatf("row%0d d_rdata", k), bus.d_rdata, tbl[k].drd);
      if (tbl[k].en && tbl[k].we) chk($sformatf("row%0d mem_wdata", k), bus.mem_wdata, B);
`ifdef MEM_ARB_PERF_EN
      chk($sformatf("row%0d perf_conflicts", k), 32'(perf_conflicts), 32'(tbl[k].perf));
`endif
    end
    ref_mem[4] = B;
    // Fetch address changes while busy: the latched address must hold.
    @(negedge clk); bus.if_req = 1'b1; bus.if_addr = 32'h0000_0082; #1;
    chk("hold stall", 32'(bus.stall), 32'd1);
    @(negedge clk); #1;
    chk("hold addr busy1", bus.mem_addr, 32'h0000_0080);
    bus.if_addr = 32'h0000_00FC;
    @(negedge clk); #1;
    chk("hold addr busy2", bus.mem_addr, 32'h0000_0080);
    chk("hold en busy2", 32'(bus.mem_en), 32'd1);
    @(negedge clk); #1;
    chk("hold if_ack", 32'(bus.if_ack), 32'd1);
    chk("hold if_rdata", bus.if_rdata, ref_mem[32]);
    bus.if_req = 1'b0;
    // Randomized traffic checked against the reference memory and latency bounds.
    ipend = 1'b0; dpend = 1'b0; istart = 0; dstart = 0; exp_drd = B;
    ia_r = '0; da_r = '0; dwd_r = '0; dwe_r = 1'b0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk); #1;
      chk("rnd stall", 32'(bus.stall), 32'((ipend & ~bus.if_ack) | (dpend & ~bus.d_ack)));
      if (bus.if_ack && bus.d_ack) chk("rnd both acks", 32'(bus.d_ack), 32'd0);
      if (bus.if_ack) begin
        chk("rnd if_ack pending", 32'(ipend), 32'd1);
        lat = cyc - istart;
        chk("rnd if latency ok", 32'(lat >= W + 1 && lat <= 2 * W + 2), 32'd1);
        chk("rnd if_rdata", bus.if_rdata, ref_mem[ia_r[7:2]]);
        ipend = 1'b0; bus.if_req = 1'b0;
      end else if (ipend && cyc - istart > 2 * W + 2) begin
        chk("rnd if timeout age", 32'(cyc - istart), 32'(2 * W + 2));
        ipend = 1'b0; bus.if_req = 1'b0;
      end else if (!ipend && $urandom_range(0, 2) == 0) begin
        ia_r = 32'($urandom_range(0, 255));
        ipend = 1'b1; istart = cyc; bus.if_req = 1'b1; bus.if_addr = ia_r;
      end
      if (bus.d_ack) begin
        chk("rnd d_ack pending", 32'(dpend), 32'd1);
        lat = cyc - dstart;
        chk("rnd d latency ok", 32'(lat >= W + 1 && lat <= 2 * W + 2), 32'd1);
        if (dwe_r) ref_mem[da_r[7:2]] = dwd_r;
        else exp_drd = ref_mem[da_r[7:2]];
        chk("rnd d_rdata", bus.d_rdata, exp_drd);
        dpend = 1'b0; bus.d_req = 1'b0;
      end else if (dpend && cyc - dstart > 2 * W + 2) begin
        chk("rnd d timeout age", 32'(cyc - dstart), 32'(2 * W + 2));
        dpend = 1'b0; bus.d_req = 1'b0;
      end else if (!dpend && $urandom_range(0, 2) == 0) begin
        da_r = 32'($urandom_range(0, 255)); dwe_r = 1'($urandom_range(0, 1)); dwd_r = $urandom;
        dpend = 1'b1; dstart = cyc;
        bus.d_req = 1'b1; bus.d_we = dwe_r; bus.d_addr = da_r; bus.d_wdata = dwd_r;
      end
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    repeat (2 * W + 4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
